// File: rtl/pe_array_sched_pkg.sv
// Shared types for the 4x4 PE matrix sequencer: PE beat encodings, FSM states,
// phase-count constants and small beat-encoding helpers.
package pe_array_sched_pkg;

  localparam int PE_PROCESS_WINDOW   = 6;
  localparam int PE_SCHED_PHASES_3X3 = 1;
  localparam int PE_SCHED_PHASES_5X5 = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ONE   = 3'd1,
    TWO   = 3'd2,
    THREE = 3'd3,
    FOUR  = 3'd4,
    FIVE  = 3'd5,
    SIX   = 3'd6
  } PE_state_t;

  typedef enum logic [2:0] {
    A_MODE = 3'd0,
    B_MODE = 3'd1,
    C_MODE = 3'd2,
    D_MODE = 3'd3,
    E_MODE = 3'd4
  } PE_weight_mode_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } pe_sched_state_t;

  // Column counter 0..5 maps onto ONE..SIX.
  function automatic PE_state_t col_to_state(input logic [2:0] col);
    return PE_state_t'(col + 3'd1);
  endfunction

  // 3x3 uses the single E phase; 5x5 walks A..D.
  function automatic PE_weight_mode_t phase_to_wmode(input logic kernel_5x5,
                                                     input logic [1:0] phase);
    return kernel_5x5 ? PE_weight_mode_t'({1'b0, phase}) : E_MODE;
  endfunction

  function automatic logic [1:0] last_phase(input logic kernel_5x5);
    return kernel_5x5 ? 2'(PE_SCHED_PHASES_5X5 - 1) : 2'(PE_SCHED_PHASES_3X3 - 1);
  endfunction

endpackage

// File: rtl/pe_array_sched_if.sv
// Buffer-read and PE-beat bundle between the sequencer (master) and the
// PE matrix with its FM/WT buffers (slave).
interface pe_array_sched_if #(
  parameter int FM_ADDR_W = 15,
  parameter int WT_ADDR_W = 9
);
  import pe_array_sched_pkg::*;

  logic                 fm_rd_en;
  logic [FM_ADDR_W-1:0] fm_rd_addr;
  logic                 wt_rd_en;
  logic [WT_ADDR_W-1:0] wt_rd_addr;
  logic                 pe_valid;
  PE_state_t            pe_state;
  PE_weight_mode_t      pe_wmode;
  logic                 pe_last;
  logic                 pe_ready;

  modport master (
    output fm_rd_en, fm_rd_addr, wt_rd_en, wt_rd_addr,
    output pe_valid, pe_state, pe_wmode, pe_last,
    input  pe_ready
  );

  modport slave (
    input  fm_rd_en, fm_rd_addr, wt_rd_en, wt_rd_addr,
    input  pe_valid, pe_state, pe_wmode, pe_last,
    output pe_ready
  );

endinterface

// File: rtl/pe_sched_addr_gen.sv
// FM row pointer and weight pointer for the PE sequencer; all arithmetic wraps
// naturally at the address width.
module pe_sched_addr_gen
  import pe_array_sched_pkg::*;
#(
  parameter int FM_ADDR_W = 15,
  parameter int WT_ADDR_W = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [FM_ADDR_W-1:0] fm_base,
  input  logic [WT_ADDR_W-1:0] wt_base,
  input  logic [2:0]           col,
  input  logic                 fm_step,
  input  logic                 wt_step,
  input  logic                 wt_rewind,
  output logic [FM_ADDR_W-1:0] fm_addr,
  output logic [WT_ADDR_W-1:0] wt_addr
);

  logic [FM_ADDR_W-1:0] fm_row;
  logic [WT_ADDR_W-1:0] wt_base_q;
  logic [WT_ADDR_W-1:0] wt_ptr;

  // fm_row steps one 6-column row per (window, channel); the weight pointer
  // steps per phase and returns to the base at every new window.
  always_ff @(posedge clk) begin
    if (rst) begin
      fm_row    <= '0;
      wt_base_q <= '0;
      wt_ptr    <= '0;
    end else if (load) begin
      fm_row    <= fm_base;
      wt_base_q <= wt_base;
      wt_ptr    <= wt_base;
    end else begin
      if (fm_step) fm_row <= fm_row + FM_ADDR_W'(PE_PROCESS_WINDOW);
      if (wt_rewind)    wt_ptr <= wt_base_q;
      else if (wt_step) wt_ptr <= wt_ptr + WT_ADDR_W'(1);
    end
  end

  assign fm_addr = fm_row + FM_ADDR_W'(col);
  assign wt_addr = wt_ptr;

endmodule

// File: rtl/pe_array_sched.sv
// Layer-pass sequencer for the 4x4 PE matrix: walks windows, channels, weight
// phases and columns. Optional perf counters under PE_SCHED_PERF_CNT_EN.
module pe_array_sched
  import pe_array_sched_pkg::*;
#(
  parameter int FM_ADDR_W = 15,
  parameter int WT_ADDR_W = 9,
  parameter int WIN_W     = 12,
  parameter int CH_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 cfg_kernel_mode,
  input  logic [WIN_W-1:0]     cfg_win_num,
  input  logic [CH_W-1:0]      cfg_ch_num,
  input  logic [FM_ADDR_W-1:0] cfg_fm_base,
  input  logic [WT_ADDR_W-1:0] cfg_wt_base,
  output logic                 busy,
  output logic                 done,
`ifdef PE_SCHED_PERF_CNT_EN
  output logic [31:0]          perf_run_cnt,
  output logic [31:0]          perf_stall_cnt,
`endif
  pe_array_sched_if.master     pe_bus
);

  pe_sched_state_t  state;
  logic             kmode_q;
  logic [WIN_W-1:0] win_q;
  logic [CH_W-1:0]  ch_q;
  logic             empty_q;

  logic [WIN_W-1:0] win_cnt;
  logic [CH_W-1:0]  ch_cnt;
  logic [1:0]       ph_cnt;
  logic [2:0]       col_cnt;

  logic             launch;
  logic             issue_p0;
  logic             col_end;
  logic             ph_end;
  logic             ch_end;
  logic             win_end;
  logic             last_ch;

  logic             vld_p1;
  PE_state_t        state_p1;
  PE_weight_mode_t  wmode_p1;
  logic             last_p1;

  logic [FM_ADDR_W-1:0] fm_addr;
  logic [WT_ADDR_W-1:0] wt_addr;

  assign launch   = (state == S_IDLE) && start;
  assign issue_p0 = (state == S_RUN) && pe_bus.pe_ready && !empty_q;

  // Loop-end flags cascade innermost (column) to outermost (window).
  assign last_ch = (ch_cnt == ch_q - CH_W'(1));
  assign col_end = (col_cnt == 3'(PE_PROCESS_WINDOW - 1));
  assign ph_end  = col_end && (ph_cnt == last_phase(kmode_q));
  assign ch_end  = ph_end && last_ch;
  assign win_end = ch_end && (win_cnt == win_q - WIN_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      kmode_q <= 1'b0;
      win_q   <= '0;
      ch_q    <= '0;
      empty_q <= 1'b0;
      win_cnt <= '0;
      ch_cnt  <= '0;
      ph_cnt  <= '0;
      col_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_RUN;
            busy    <= 1'b1;
            kmode_q <= cfg_kernel_mode;
            win_q   <= cfg_win_num;
            ch_q    <= cfg_ch_num;
            empty_q <= (cfg_win_num == '0) || (cfg_ch_num == '0);
            win_cnt <= '0;
            ch_cnt  <= '0;
            ph_cnt  <= '0;
            col_cnt <= '0;
          end
        end
        S_RUN: begin
          if (empty_q) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (issue_p0) begin
            col_cnt <= col_end ? 3'd0 : col_cnt + 3'd1;
            if (col_end) ph_cnt <= ph_end ? 2'd0 : ph_cnt + 2'd1;
            if (ph_end)  ch_cnt <= ch_end ? '0 : ch_cnt + CH_W'(1);
            if (ch_end)  win_cnt <= win_cnt + WIN_W'(1);
            if (win_end) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          state <= S_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  pe_sched_addr_gen #(
    .FM_ADDR_W (FM_ADDR_W),
    .WT_ADDR_W (WT_ADDR_W)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (launch),
    .fm_base   (cfg_fm_base),
    .wt_base   (cfg_wt_base),
    .col       (col_cnt),
    .fm_step   (issue_p0 && ph_end),
    .wt_step   (issue_p0 && col_end),
    .wt_rewind (issue_p0 && ch_end),
    .fm_addr   (fm_addr),
    .wt_addr   (wt_addr)
  );

  assign pe_bus.fm_rd_en   = issue_p0;
  assign pe_bus.fm_rd_addr = fm_addr;
  assign pe_bus.wt_rd_en   = issue_p0 && (col_cnt == 3'd0);
  assign pe_bus.wt_rd_addr = wt_addr;

  // p0 -> p1: beat descriptor follows the 1-cycle buffer read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      state_p1 <= IDLE;
      wmode_p1 <= A_MODE;
      last_p1  <= 1'b0;
    end else begin
      vld_p1   <= issue_p0;
      state_p1 <= issue_p0 ? col_to_state(col_cnt) : IDLE;
      if (issue_p0) wmode_p1 <= phase_to_wmode(kmode_q, ph_cnt);
      last_p1  <= issue_p0 && last_ch;
    end
  end

  assign pe_bus.pe_valid = vld_p1;
  assign pe_bus.pe_state = state_p1;
  assign pe_bus.pe_wmode = wmode_p1;
  assign pe_bus.pe_last  = last_p1;

`ifdef PE_SCHED_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_run_cnt   <= '0;
      perf_stall_cnt <= '0;
    end else if (launch) begin
      perf_run_cnt   <= '0;
      perf_stall_cnt <= '0;
    end else if (state == S_RUN) begin
      perf_run_cnt <= sat_inc(perf_run_cnt);
      if (!pe_bus.pe_ready) perf_stall_cnt <= sat_inc(perf_stall_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_pe_array_sched.sv
// Bench for pe_array_sched: table of pass configurations checked cycle by cycle
// against a loop-nest model, plus reset and ignored-start sequences.
module tb_pe_array_sched;
  import pe_array_sched_pkg::*;

  localparam int FM_ADDR_W = 15;
  localparam int WT_ADDR_W = 9;
  localparam int WIN_W     = 12;
  localparam int CH_W      = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic                 cfg_kernel_mode;
  logic [WIN_W-1:0]     cfg_win_num;
  logic [CH_W-1:0]      cfg_ch_num;
  logic [FM_ADDR_W-1:0] cfg_fm_base;
  logic [WT_ADDR_W-1:0] cfg_wt_base;
  logic                 busy;
  logic                 done;
`ifdef PE_SCHED_PERF_CNT_EN
  logic [31:0]          perf_run_cnt;
  logic [31:0]          perf_stall_cnt;
`endif

  pe_array_sched_if #(.FM_ADDR_W(FM_ADDR_W), .WT_ADDR_W(WT_ADDR_W)) bus ();

  pe_array_sched #(
    .FM_ADDR_W (FM_ADDR_W),
    .WT_ADDR_W (WT_ADDR_W),
    .WIN_W     (WIN_W),
    .CH_W      (CH_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .cfg_kernel_mode (cfg_kernel_mode),
    .cfg_win_num     (cfg_win_num),
    .cfg_ch_num      (cfg_ch_num),
    .cfg_fm_base     (cfg_fm_base),
    .cfg_wt_base     (cfg_wt_base),
    .busy            (busy),
    .done            (done),
`ifdef PE_SCHED_PERF_CNT_EN
    .perf_run_cnt    (perf_run_cnt),
    .perf_stall_cnt  (perf_stall_cnt),
`endif
    .pe_bus          (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  typedef struct {
    int fm;
    int wt;
    int has_wt;
    int st;
    int wm;
    int last;
  } beat_t;

  typedef struct {
    logic km;
    int   win;
    int   ch;
    int   fmb;
    int   wtb;
    int   stall_kind;  // 0 always ready, 1 low in [lo,hi], 2 random
    int   lo;
    int   hi;
    int   poke;        // cycle of an extra start pulse that must be ignored
    int   exp_issues;  // -1 = not tabulated
    int   exp_done;
  } vec_t;

  PE_state_t       col_st [6] = '{ONE, TWO, THREE, FOUR, FIVE, SIX};
  PE_weight_mode_t ph_wm  [4] = '{A_MODE, B_MODE, C_MODE, D_MODE};

  task automatic run_pass(input vec_t v, input string tag);
    beat_t exp_q[$];
    beat_t b;
    int    P, n, issued, exp_done, got_issues, got_done;
    bit    rdy, exp_rd, prev_rd;

    P = v.km ? 4 : 1;
    for (int w = 0; w < v.win; w++)
      for (int c = 0; c < v.ch; c++)
        for (int p = 0; p < P; p++)
          for (int s = 0; s < 6; s++) begin
            b.fm     = (v.fmb + 6 * (w * v.ch + c) + s) % 32768;
            b.wt     = (v.wtb + c * P + p) % 512;
            b.has_wt = (s == 0);
            b.st     = int'(col_st[s]);
            b.wm     = v.km ? int'(ph_wm[p]) : int'(E_MODE);
            b.last   = (c == v.ch - 1);
            exp_q.push_back(b);
          end
    n = exp_q.size();

    @(posedge clk); #1;
    start           = 1'b1;
    cfg_kernel_mode = v.km;
    cfg_win_num     = WIN_W'(v.win);
    cfg_ch_num      = CH_W'(v.ch);
    cfg_fm_base     = FM_ADDR_W'(v.fmb);
    cfg_wt_base     = WT_ADDR_W'(v.wtb);
    bus.pe_ready    = 1'b1;
    issued     = 0;
    exp_done   = (n == 0) ? 2 : -1;
    prev_rd    = 1'b0;
    got_issues = 0;
    got_done   = -1;

    for (int k = 1; k < 4000; k++) begin
      @(posedge clk); #1;
      start = (k == v.poke);
      if (k == v.poke) begin
        cfg_kernel_mode = 1'b1;
        cfg_win_num     = WIN_W'(7);
        cfg_ch_num      = CH_W'(7);
        cfg_fm_base     = FM_ADDR_W'(123);
      end
      case (v.stall_kind)
        1:       rdy = !(k >= v.lo && k <= v.hi);
        2:       rdy = ($urandom_range(0, 3) != 0);
        default: rdy = 1'b1;
      endcase
      bus.pe_ready = rdy;
      @(negedge clk);
      exp_rd = (n > 0) && rdy && (issued < n);
      chk($sformatf("%s busy c%0d", tag, k), int'(busy), int'(exp_done < 0 || k < exp_done));
      chk($sformatf("%s done c%0d", tag, k), int'(done), int'(k == exp_done));
      chk($sformatf("%s fm_rd_en c%0d", tag, k), int'(bus.fm_rd_en), int'(exp_rd));
      if (exp_rd) begin
        chk($sformatf("%s fm_rd_addr c%0d", tag, k), int'(bus.fm_rd_addr), exp_q[issued].fm);
        chk($sformatf("%s wt_rd_en c%0d", tag, k), int'(bus.wt_rd_en), exp_q[issued].has_wt);
        if (exp_q[issued].has_wt != 0)
          chk($sformatf("%s wt_rd_addr c%0d", tag, k), int'(bus.wt_rd_addr), exp_q[issued].wt);
      end else begin
        chk($sformatf("%s wt_rd_en idle c%0d", tag, k), int'(bus.wt_rd_en), 0);
      end
      chk($sformatf("%s pe_valid c%0d", tag, k), int'(bus.pe_valid), int'(prev_rd));
      if (prev_rd) begin
        chk($sformatf("%s pe_state c%0d", tag, k), int'(bus.pe_state), exp_q[issued-1].st);
        chk($sformatf("%s pe_wmode c%0d", tag, k), int'(bus.pe_wmode), exp_q[issued-1].wm);
        chk($sformatf("%s pe_last c%0d", tag, k), int'(bus.pe_last), exp_q[issued-1].last);
      end else begin
        chk($sformatf("%s pe_last idle c%0d", tag, k), int'(bus.pe_last), 0);
      end
      if (bus.fm_rd_en) got_issues++;
      if (done && got_done < 0) got_done = k;
      prev_rd = exp_rd;
      if (exp_rd) begin
        issued++;
        if (issued == n) exp_done = k + 2;
      end
      if (exp_done >= 0 && k >= exp_done) break;
    end
    start = 1'b0;

    chk({tag, " done cycle vs model"}, got_done, exp_done);
    if (v.exp_issues >= 0) chk({tag, " issue count"}, got_issues, v.exp_issues);
    if (v.exp_done >= 0)   chk({tag, " done cycle"}, got_done, v.exp_done);

    for (int j = 0; j < 2; j++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("%s post busy %0d", tag, j), int'(busy), 0);
      chk($sformatf("%s post done %0d", tag, j), int'(done), 0);
      chk($sformatf("%s post fm_rd_en %0d", tag, j), int'(bus.fm_rd_en), 0);
      chk($sformatf("%s post pe_valid %0d", tag, j), int'(bus.pe_valid), 0);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " busy"}, int'(busy), 0);
    chk({tag, " done"}, int'(done), 0);
    chk({tag, " fm_rd_en"}, int'(bus.fm_rd_en), 0);
    chk({tag, " wt_rd_en"}, int'(bus.wt_rd_en), 0);
    chk({tag, " pe_valid"}, int'(bus.pe_valid), 0);
    chk({tag, " pe_last"}, int'(bus.pe_last), 0);
    chk({tag, " pe_state"}, int'(bus.pe_state), int'(IDLE));
    chk({tag, " pe_wmode"}, int'(bus.pe_wmode), int'(A_MODE));
    chk({tag, " fm_rd_addr"}, int'(bus.fm_rd_addr), 0);
    chk({tag, " wt_rd_addr"}, int'(bus.wt_rd_addr), 0);
  endtask

  task automatic mid_pass_reset();
    @(posedge clk); #1;
    start           = 1'b1;
    cfg_kernel_mode = 1'b1;
    cfg_win_num     = WIN_W'(2);
    cfg_ch_num      = CH_W'(2);
    cfg_fm_base     = FM_ADDR_W'(16'h300);
    cfg_wt_base     = WT_ADDR_W'(9'h30);
    bus.pe_ready    = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      rst   = (k == 20);
      @(negedge clk);
      if (k == 20) begin
        chk("midrst running fm_rd_en", int'(bus.fm_rd_en), 1);
        chk("midrst running busy", int'(busy), 1);
      end
      if (k == 21) chk_reset_outputs("midrst");
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst stays idle busy", int'(busy), 0);
    chk("midrst stays idle fm_rd_en", int'(bus.fm_rd_en), 0);
  endtask

  vec_t vecs [8];

  initial begin
    vecs[0] = '{1'b0, 1, 1, 'h100, 'h10, 0, 0, 0, 3, 6, 8};
    vecs[1] = '{1'b1, 2, 2, 0, 0, 0, 0, 0, -1, 96, 98};
    vecs[2] = '{1'b0, 1, 2, 0, 0, 1, 3, 5, 17, 12, 17};
    vecs[3] = '{1'b0, 0, 3, 'h40, 'h4, 0, 0, 0, -1, 0, 2};
    vecs[4] = '{1'b1, 2, 0, 'h40, 'h4, 0, 0, 0, -1, 0, 2};
    vecs[5] = '{1'b0, 1, 2, 32765, 511, 0, 0, 0, -1, 12, 14};
    vecs[6] = '{1'b1, 2, 3, 32760, 509, 2, 0, 0, -1, -1, -1};
    vecs[7] = '{1'b0, 3, 2, 'h200, 'h20, 2, 0, 0, 5, -1, -1};

    rst             = 1'b1;
    start           = 1'b0;
    cfg_kernel_mode = 1'b0;
    cfg_win_num     = '0;
    cfg_ch_num      = '0;
    cfg_fm_base     = '0;
    cfg_wt_base     = '0;
    bus.pe_ready    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_pass(vecs[i], $sformatf("v%0d", i));
`ifdef PE_SCHED_PERF_CNT_EN
      if (i == 2) begin
        chk("perf_run_cnt", int'(perf_run_cnt), 15);
        chk("perf_stall_cnt", int'(perf_stall_cnt), 3);
      end
`endif
      if (i == 4) begin
        mid_pass_reset();
        rst = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pe_array_sched.md
# pe_array_sched

Sequencer for the 4×4 PE matrix. It walks one layer pass through windows, input channels and weight phases. For each step it issues fm buffer and weight buffer reads, and drives the PE array's `PE_state_t` / `PE_weight_mode_t` beat by beat, aligned to the 1‑cycle buffer read latency. It sits between the layer/instruction decoder (config + start) and the PE matrix plus its FM/WT buffers.

## Interface
- `FM_ADDR_W`, default 15: fm buffer address width (≥ $clog2(CONF_FM_BUF_DEPTH)).
- `WT_ADDR_W`, default 9: weight buffer address width (≥ $clog2(CONF_WT_BUF_DEPTH)).
- `WIN_W`, default 12: width of the window count.
- `CH_W`, default 8: width of the channel count (channel count ≤ 250).

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active‑high reset.
- `start` in 1: one‑cycle pulse; latches all `cfg_*` inputs. Ignored while `busy`.
- `cfg_kernel_mode` in 1: 0 = 3×3, 1 = 5×5.
- `cfg_win_num` in WIN_W: number of 6‑column windows.
- `cfg_ch_num` in CH_W: number of input channels.
- `cfg_fm_base` in FM_ADDR_W: fm start address.
- `cfg_wt_base` in WT_ADDR_W: weight start address.
- `pe_ready` in 1: PE array accepts a new issue this cycle.
- `busy` out 1: a pass is in progress.
- `done` out 1: one‑cycle pulse at the end of a pass.
- `fm_rd_en` out 1, `fm_rd_addr` out FM_ADDR_W: fm buffer read.
- `wt_rd_en` out 1, `wt_rd_addr` out WT_ADDR_W: weight buffer read.
- `pe_valid` out 1: beat valid, aligned with returned buffer data.
- `pe_state` out PE_state_t: column index within the window.
- `pe_wmode` out PE_weight_mode_t: weight mode for this beat.
- `pe_last` out 1: beat belongs to the last channel of the window (PE flushes psum).

## Operation
- FSM states: `S_IDLE`, `S_RUN`, `S_DRAIN`, `S_DONE`.
  - `S_IDLE` + `start` → `S_RUN`.
  - If `cfg_win_num==0` or `cfg_ch_num==0` → `S_DONE` directly, with no reads issued.
  - `S_RUN`, last beat issued → `S_DRAIN` (1 cycle) → `S_DONE` (1 cycle, `done`=1) → `S_IDLE`.
- Phase set per kernel mode:
  - 3×3: P=1 phase, {E_MODE}.
  - 5×5: P=4 phases, {A,B,C,D} in that order (9+6+6+4 = 25 taps).
- Loop order, outermost first: window w (0..win−1), channel c (0..ch−1), phase p (0..P−1), column s (ONE..SIX).
- Issue cycle: a cycle in `S_RUN` with `pe_ready`=1. Exactly one fm read per issue cycle.
  - `fm_rd_addr = fm_base + 6·(w·ch + c) + (s−1)`, kept as a running row pointer advanced by 6 per (w,c).
- `wt_rd_en`=1 only on issue cycles with s=ONE.
  - `wt_rd_addr = wt_base + c·P + p`.
  - Weight pointer rewinds to `wt_base` at every new window.
- Address arithmetic wraps modulo 2^FM_ADDR_W / 2^WT_ADDR_W; no error flag.
- Pass length with no stalls: N = win·ch·P·6 issue cycles.

## Timing
- Reset: FSM=`S_IDLE`; all counters 0; `busy`=`done`=`fm_rd_en`=`wt_rd_en`=`pe_valid`=`pe_last`=0; `pe_state`=IDLE; `pe_wmode`=A_MODE; addresses 0.
- `start` at cycle 0 → `busy`=1 and first issue possible at cycle 1.
- `pe_valid`/`pe_state`/`pe_wmode`/`pe_last` are registered copies of the issue cycle, valid 1 cycle later.
- `pe_ready`=0: no read, counters hold, and `pe_valid`=0 the following cycle. A beat issued in the previous cycle still emerges; the PE array absorbs it.
- `done` is asserted 1 cycle after the last `pe_valid`. `busy` drops in the same cycle as `done`.
- `start` in the same cycle as `done` is ignored.
- `rst` mid‑pass aborts immediately; in‑flight beats are discarded.

## Configuration
- `PE_SCHED_PERF_CNT_EN` defined: adds outputs `perf_run_cnt` (32) and `perf_stall_cnt` (32).
  - Both clear on `start` and saturate.
  - `perf_run_cnt` counts cycles in `S_RUN`.
  - `perf_stall_cnt` counts `S_RUN` cycles with `pe_ready`=0.
- `PE_SCHED_PERF_CNT_EN` undefined: neither port nor counters exist; behaviour is otherwise identical.

## Structure
- Shared package gets `pe_sched_state_t` (the 4 FSM states) and a `PE_SCHED_PHASES_5X5 = 4` constant.
- Reuse `PE_state_t`, `PE_weight_mode_t`, `PE_PROCESS_WINDOW`.
- One sub‑module, `pe_sched_addr_gen`: holds the fm/wt pointers and the wrap arithmetic, advanced by enable pulses from the loop counters.

## Test plan
- 3×3, win=1, ch=1, base fm=0x100, wt=0x10, `pe_ready`=1:
  - fm reads 0x100–0x105 on cycles 1–6.
  - One wt read to 0x10.
  - `pe_valid` cycles 2–7 with ONE..SIX, E_MODE, `pe_last`=1.
  - `done` at cycle 8.
- 5×5, win=2, ch=2, fm=0, wt=0:
  - 96 issues.
  - wt addrs 0,1,2,3,4,5,6,7, then 0..7 again for window 1.
  - fm addrs 0–5 (×4 phases), then 6–11, 12–17, 18–23.
  - `pe_last` only on c=1 beats.
- 3×3, win=1, ch=2, `pe_ready` low for cycles 3–5: counters hold, no reads, `pe_valid` gap; total 12 beats; `done` delayed by 3 cycles.
- Config win=0 or ch=0: no `rd_en`; `done` pulse at cycle 2.
- Wrap and reset:
  - fm_base=2^15−3 → addrs wrap to 0.
  - `rst` at mid‑pass cycle 20 → all outputs at reset values next cycle.
  - `start` during `busy` is ignored.
- With `PE_SCHED_PERF_CNT_EN` and scenario 3: `perf_stall_cnt`=3, `perf_run_cnt`=15.
